// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the shared single-ported memory (fetch reads vs Exe/Mem loads/stores).
// Define MEMARB_FAIR_EN to bound how long fetch can be starved by back-to-back data grants.
module mem_arbiter #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned FAIR_LIMIT  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_F,
  output logic          stall_M
);

  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e        state;
  logic [CW-1:0] cnt;
  logic          owner_data;
  logic          pick_data;

  assign stall_F = i_req & ~i_ack;
  assign stall_M = d_req & ~d_ack;

`ifdef MEMARB_FAIR_EN
  localparam int unsigned FW = $clog2(FAIR_LIMIT + 2);

  logic [FW-1:0] fair_cnt;

  // Once enough data grants have gone by while fetch waited, fetch wins the next arbitration.
  assign pick_data = d_req & ~(i_req & (fair_cnt >= FW'(FAIR_LIMIT)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fair_cnt <= '0;
    end else if (state == StIdle && (i_req || d_req)) begin
      if (pick_data && i_req) begin
        fair_cnt <= fair_cnt + FW'(1);
      end else begin
        fair_cnt <= '0;
      end
    end
  end
`else
  assign pick_data = d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= '0;
      owner_data <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        StIdle: begin
          if (i_req || d_req) begin
            state      <= StAccess;
            cnt        <= CW'(WAIT_CYCLES);
            owner_data <= pick_data;
            mem_en     <= 1'b1;
            mem_we     <= pick_data & d_we;
            mem_addr   <= pick_data ? d_addr : i_addr;
            mem_wdata  <= pick_data ? d_wdata : '0;
          end
        end
        StAccess: begin
          if (cnt == '0) begin
            state     <= StDone;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (!mem_we) begin
              if (owner_data) begin
                d_rdata <= mem_rdata;
              end else begin
                i_rdata <= mem_rdata;
              end
            end
            if (owner_data) begin
              d_ack <= 1'b1;
            end else begin
              i_ack <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model plus directed literal checks.
// Honours MEMARB_FAIR_EN the same way as the design.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned W  = 1;
  localparam int unsigned FL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
  logic          i_ack, d_ack, mem_en, mem_we, stall_F, stall_M;

  logic          z_i_req;
  logic [AW-1:0] z_i_addr, z_mem_addr;
  logic [DW-1:0] z_mem_rdata, z_i_rdata, z_d_rdata, z_mem_wdata;
  logic          z_i_ack, z_d_ack, z_mem_en, z_mem_we, z_stall_F, z_stall_M;

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W), .FAIR_LIMIT(FL)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_F(stall_F), .stall_M(stall_M)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(0), .FAIR_LIMIT(FL)) dut0 (
    .clk(clk), .rst(rst),
    .i_req(z_i_req), .i_addr(z_i_addr), .i_ack(z_i_ack), .i_rdata(z_i_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
    .d_ack(z_d_ack), .d_rdata(z_d_rdata),
    .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_rdata(z_mem_rdata), .stall_F(z_stall_F), .stall_M(z_stall_M)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  // Reference model: one in-flight transaction, described by its grant cycle.
  logic [DW-1:0] mem_model [16];
  logic          t_act, t_data, t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  int unsigned   t_g;
`ifdef MEMARB_FAIR_EN
  int unsigned   fair;
`endif
  logic [DW-1:0] m_irdata, m_drdata;
  logic          e_iack, e_dack, e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          p_iack, p_dack, f_pend, d_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a[5:2]);
  endfunction

  task automatic model_reset();
    t_act = 1'b0;
`ifdef MEMARB_FAIR_EN
    fair = 0;
`endif
    m_irdata = '0;
    m_drdata = '0;
    p_iack   = 1'b0;
    p_dack   = 1'b0;
    f_pend   = 1'b0;
    d_pend   = 1'b0;
  endtask

  task automatic model_step();
    logic gd;
    e_iack = 1'b0; e_dack = 1'b0; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (t_act && cyc == t_g + W + 2) begin
      if (t_data) e_dack = 1'b1;
      else e_iack = 1'b1;
      if (t_we) mem_model[idx(t_addr)] = t_wdata;
      else if (t_data) m_drdata = mem_model[idx(t_addr)];
      else m_irdata = mem_model[idx(t_addr)];
      t_act = 1'b0;
    end else if (t_act) begin
      e_en = 1'b1; e_we = t_we; e_addr = t_addr; e_wdata = t_wdata;
    end else if (i_req || d_req) begin
      gd = d_req;
`ifdef MEMARB_FAIR_EN
      if (i_req && fair >= FL) gd = 1'b0;
      if (gd && i_req) fair++;
      else fair = 0;
`endif
      t_act = 1'b1; t_g = cyc; t_data = gd; t_we = gd & d_we;
      t_addr  = gd ? d_addr : i_addr;
      t_wdata = gd ? d_wdata : '0;
    end
  endtask

  task automatic step_begin();
    model_step();
    if (t_act && cyc == t_g + W + 1) mem_rdata = mem_model[idx(t_addr)];
    else mem_rdata = $urandom;
    #1;
    chk("i_ack", i_ack, e_iack);
    chk("d_ack", d_ack, e_dack);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    if (!(e_en && !e_we)) chk("mem_wdata", mem_wdata, e_wdata);
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
    chk("stall_F", stall_F, i_req & ~e_iack);
    chk("stall_M", stall_M, d_req & ~e_dack);
  endtask

  task automatic step_end();
    p_iack = e_iack;
    p_dack = e_dack;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom_range(0, 15) * 4);
  endfunction

  // Requesters hold their request until acked, then may issue a new one the next cycle.
  task automatic drive_reqs(input bit fhold, input bit dhold, input bit quiet);
    if (f_pend && p_iack) f_pend = 1'b0;
    if (!f_pend && !quiet && (fhold || $urandom_range(0, 2) != 0)) begin
      f_pend = 1'b1;
      i_addr = rand_addr();
    end else if (!f_pend) begin
      i_addr = $urandom;
    end
    i_req = f_pend;
    if (d_pend && p_dack) d_pend = 1'b0;
    if (!d_pend && !quiet && (dhold || $urandom_range(0, 2) != 0)) begin
      d_pend  = 1'b1;
      d_addr  = rand_addr();
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
    end else if (!d_pend) begin
      d_addr = $urandom;
    end
    d_req = d_pend;
  endtask

  task automatic run(input int n, input bit fhold, input bit dhold, input bit quiet);
    for (int k = 0; k < n; k++) begin
      drive_reqs(fhold, dhold, quiet);
      step_begin();
      step_end();
    end
  endtask

  task automatic fetch_test();
    mem_model[4] = 32'hDEADBEEF;
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h10;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) i_req = 1'b0;
      step_begin();
      chk("t1_mem_en", mem_en, (k == 1 || k == 2));
      if (k == 1 || k == 2) chk("t1_mem_addr", mem_addr, 32'h10);
      chk("t1_i_ack", i_ack, (k == 3));
      chk("t1_stall_F", stall_F, (k < 3));
      if (k == 3) chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
      step_end();
    end
  endtask

  initial begin
    int dcnt, icnt, dbefore;
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    z_i_req = 1'b0; z_i_addr = '0; z_mem_rdata = 32'h0BADF00D;
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_i_ack", i_ack, 1'b0);
    chk("rst_d_ack", d_ack, 1'b0);
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    chk("rst_mem_addr", mem_addr, '0);
    rst = 1'b0;

    fetch_test();

    // Both requesters at once: data first, fetch in the IDLE cycle after data's DONE.
    mem_model[8] = 32'hA5A50020;
    for (int k = 0; k < 9; k++) begin
      i_req = (k <= 7); i_addr = 32'h0C;
      d_req = (k <= 3); d_we = 1'b0; d_addr = 32'h20; d_wdata = '0;
      step_begin();
      chk("t2_d_ack", d_ack, (k == 3));
      chk("t2_i_ack", i_ack, (k == 7));
      chk("t2_stall_F", stall_F, (k < 7));
      chk("t2_mem_en", mem_en, (k == 1 || k == 2 || k == 5 || k == 6));
      if (k == 1) chk("t2_mem_addr_d", mem_addr, 32'h20);
      if (k == 5) chk("t2_mem_addr_i", mem_addr, 32'h0C);
      if (k == 3) chk("t2_d_rdata", d_rdata, 32'hA5A50020);
      step_end();
    end

    // Store leaves d_rdata alone.
    for (int k = 0; k < 5; k++) begin
      i_req = 1'b0;
      d_req = (k <= 3); d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
      step_begin();
      chk("t3_mem_we", mem_we, (k == 1 || k == 2));
      if (k == 1 || k == 2) begin
        chk("t3_mem_addr", mem_addr, 32'h40);
        chk("t3_mem_wdata", mem_wdata, 32'h12345678);
      end
      chk("t3_d_ack", d_ack, (k == 3));
      if (k >= 3) chk("t3_d_rdata", d_rdata, 32'hA5A50020);
      step_end();
    end

    run(600, 1'b0, 1'b0, 1'b0);
    run(200, 1'b0, 1'b1, 1'b0);
    run(20, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a load.
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    step_begin();
    step_end();
    step_begin();
    chk("rs_mem_en_before", mem_en, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_mem_en", mem_en, 1'b0);
    chk("rs_mem_addr", mem_addr, '0);
    chk("rs_d_ack", d_ack, 1'b0);
    chk("rs_i_rdata", i_rdata, '0);
    chk("rs_d_rdata", d_rdata, '0);
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step_begin();
      step_end();
    end
    fetch_test();

    // Continuous data traffic with fetch waiting.
    dcnt = 0; icnt = 0; dbefore = -1;
    for (int k = 0; k < 40; k++) begin
      drive_reqs(1'b1, 1'b1, 1'b0);
      step_begin();
      if (i_ack && dbefore < 0) dbefore = dcnt;
      if (i_ack) icnt++;
      if (d_ack) dcnt++;
      step_end();
    end
`ifdef MEMARB_FAIR_EN
    chk("fair_dacks_before_iack", 64'(dbefore), 64'd4);
`else
    chk("starve_i_acks", 64'(icnt), 64'd0);
    chk("starve_d_acks", 64'(dcnt), 64'd10);
`endif
    run(20, 1'b0, 1'b0, 1'b1);

    // Zero wait-state instance: access in cycle 1, ack in cycle 2, next grant in cycle 3.
    z_i_req = 1'b1; z_i_addr = 32'h8;
    for (int k = 0; k < 5; k++) begin
      chk("w0_mem_en", z_mem_en, (k == 1 || k == 4));
      if (k == 1) chk("w0_mem_addr", z_mem_addr, 32'h8);
      chk("w0_i_ack", z_i_ack, (k == 2));
      if (k == 2) chk("w0_i_rdata", z_i_rdata, 32'h0BADF00D);
      @(posedge clk);
      #1;
    end
    z_i_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
